ntt_address_generator: RTL
==========================

Name: ntt_address_generator

Overview:
- Upstream address-generation stage for the radix-2, 4-BFU NTT datapath over N = 2^ADDR_W coefficients.
- Each beat it emits the 8 logical coefficient addresses for 4 butterflies: an (a, b) pair per BFU.
- These feed directly into the conflict-free memory map stage, which converts them to bank/row.
- Sequences all ADDR_W stages from one start pulse, with a valid/ready output handshake.

Parameters:
ADDR_W, 10, log2(N); logical address width; also the number of stages. Beats per stage = 2^(ADDR_W-3). Legal values: 4 or more.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to run a full transform; honoured only in IDLE
out_ready  input  1  downstream accepts the current beat
out_valid  output  1  old_address_0..7 and stage_index hold a valid beat
old_address_0 .. old_address_7  output  ADDR_W each  old_address_{2k} = butterfly k input a; old_address_{2k+1} = input b
stage_index  output  4  stage of the current beat, 0..ADDR_W-1
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- One clock; reset is asynchronous and active-high on rst.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Counters: stage s (0..ADDR_W-1) and beat c (0..2^(ADDR_W-3)-1).
- Per beat: half-span h = 2^(ADDR_W-1-s); butterfly index j = 4c+k for k = 0..3.
  - a = ((j >> (ADDR_W-1-s)) << (ADDR_W-s)) | (j & (h-1))
  - b = a + h
  - All arithmetic is unsigned at ADDR_W bits; no overflow is possible.
- Beat order: c increments; at wrap c returns to 0 and s increments.
- Conflict-free guarantee: the 8 addresses of any beat map to 8 distinct banks under bank = addr[2:0] with bit2 inverted by XOR(addr[ADDR_W-1:3]).
- FSM:
  - IDLE: start=1 -> RUN, with s=0, c=0.
  - RUN: load condition is (!out_valid || out_ready). When it holds, the output register loads the beat for (s, c), out_valid goes to 1, and the counters advance. After loading s=ADDR_W-1, c=max -> DRAIN.
  - DRAIN: out_valid && out_ready -> out_valid=0, done=1 for one cycle, -> IDLE.
- Latency: start sampled at edge T; first out_valid asserted after edge T+1. With out_ready held high, there is one beat per cycle and no bubbles at stage boundaries.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable and the counters freeze.
- start while busy: ignored, with no effect on counters. start in the same cycle as done: ignored (FSM is still in DRAIN).
- rst asserted mid-transform: immediate return to reset values; no done pulse; a partial beat is never emitted.
- busy = (state != IDLE). done is registered.

Optional Feature:
- Macro: NTT_TWIDDLE_INDEX_EN.
- Defined:
  - Adds output ports twiddle_index_0..3, each ADDR_W bits wide, registered alongside the addresses.
  - twiddle_index_k = 2^s + (j >> (ADDR_W-1-s)) for the Cooley-Tukey bit-reversed zeta table. Stage 0 gives 1 for all k.
  - Reset value 0; follows the same hold/stall rules as the addresses.
- Not defined: the ports are absent and the behaviour is otherwise identical.

Test Plan (ADDR_W=10):
1. Reset, then a start pulse with out_ready=1 -> first beat (s=0): 0,512,1,513,2,514,3,515. Exactly 1280 beats follow, with no gaps, then done for one cycle; busy falls with done.
2. Beat s=7, c=0 -> 0,4,1,5,2,6,3,7. Beat s=9, c=127 -> 1016..1023 in order. stage_index matches s.
3. Toggle out_ready pseudo-randomly -> outputs stable whenever out_valid=1 and out_ready=0. Beat sequence is identical to scenario 1; still 1280 accepted beats.
4. Pulse start at beats 5 and 600 of a run -> ignored; sequence and done timing unchanged.
5. Assert rst at beat 700 -> all outputs 0 immediately; no done. A fresh start then restarts at s=0, c=0.
6. All 1280 beats through a bank-map model -> 8 distinct banks per beat. With NTT_TWIDDLE_INDEX_EN: s=0 beats give twiddle 1; s=9, c=0 gives 512,513,514,515.

Source files
------------

// File: rtl/ntt_address_generator.sv
// Address generator for a radix-2, 4-BFU NTT: emits 8 butterfly addresses per beat over all stages.
// Optional twiddle index outputs are enabled with the NTT_TWIDDLE_INDEX_EN macro.
module ntt_address_generator #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] old_address_0,
    output logic [ADDR_W-1:0] old_address_1,
    output logic [ADDR_W-1:0] old_address_2,
    output logic [ADDR_W-1:0] old_address_3,
    output logic [ADDR_W-1:0] old_address_4,
    output logic [ADDR_W-1:0] old_address_5,
    output logic [ADDR_W-1:0] old_address_6,
    output logic [ADDR_W-1:0] old_address_7,
    output logic [3:0]        stage_index,
    output logic              busy,
`ifdef NTT_TWIDDLE_INDEX_EN
    output logic [ADDR_W-1:0] twiddle_index_0,
    output logic [ADDR_W-1:0] twiddle_index_1,
    output logic [ADDR_W-1:0] twiddle_index_2,
    output logic [ADDR_W-1:0] twiddle_index_3,
`endif
    output logic              done
);

    localparam int                BEAT_W    = ADDR_W - 3;
    localparam logic [BEAT_W-1:0] BEAT_MAX  = '1;
    localparam logic [3:0]        STAGE_MAX = 4'(ADDR_W - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // while out_valid is high and out_ready low, every output and counter holds.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [BEAT_W-1:0] c_q, c_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [3:0]        stage_out_q, stage_out_d;
    logic [ADDR_W-1:0] addr_q [8];
    logic [ADDR_W-1:0] addr_d [8];
    logic [ADDR_W-1:0] beat_addr [8];
`ifdef NTT_TWIDDLE_INDEX_EN
    logic [ADDR_W-1:0] tw_q [4];
    logic [ADDR_W-1:0] tw_d [4];
    logic [ADDR_W-1:0] beat_tw [4];
`endif

    // Shift that isolates the group number of butterfly j in stage s.
    function automatic logic [4:0] span_shift(input logic [3:0] s);
        return 5'(ADDR_W - 1) - {1'b0, s};
    endfunction

    function automatic logic [ADDR_W-1:0] bfu_index(input logic [BEAT_W-1:0] c,
                                                    input logic [1:0] k);
        return {1'b0, c, k};
    endfunction

    // Input a: group number moved up one bit, position within the half-span kept.
    function automatic logic [ADDR_W-1:0] calc_a(input logic [ADDR_W-1:0] j,
                                                 input logic [3:0] s);
        logic [4:0]        sh;
        logic [ADDR_W-1:0] mask;
        sh   = span_shift(s);
        mask = (ONE << sh) - ONE;
        return ((j >> sh) << (sh + 5'd1)) | (j & mask);
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            beat_addr[2*k]   = calc_a(bfu_index(c_q, 2'(k)), s_q);
            beat_addr[2*k+1] = calc_a(bfu_index(c_q, 2'(k)), s_q) + (ONE << span_shift(s_q));
        end
    end

`ifdef NTT_TWIDDLE_INDEX_EN
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            beat_tw[k] = (ONE << s_q) + (bfu_index(c_q, 2'(k)) >> span_shift(s_q));
        end
    end
`endif

    logic load;
    assign load = !valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        stage_out_d = stage_out_q;
        addr_d      = addr_q;
`ifdef NTT_TWIDDLE_INDEX_EN
        tw_d        = tw_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    c_d     = '0;
                end
            end
            ST_RUN: begin
                if (load) begin
                    valid_d     = 1'b1;
                    stage_out_d = s_q;
                    addr_d      = beat_addr;
`ifdef NTT_TWIDDLE_INDEX_EN
                    tw_d        = beat_tw;
`endif
                    if (c_q == BEAT_MAX) begin
                        c_d = '0;
                        if (s_q == STAGE_MAX) begin
                            s_d     = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            s_d = s_q + 4'd1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // The last beat is still registered; finish once it is taken.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            stage_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                addr_q[i] <= '0;
            end
`ifdef NTT_TWIDDLE_INDEX_EN
            for (int i = 0; i < 4; i++) begin
                tw_q[i] <= '0;
            end
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            stage_out_q <= stage_out_d;
            addr_q      <= addr_d;
`ifdef NTT_TWIDDLE_INDEX_EN
            tw_q        <= tw_d;
`endif
        end
    end

    assign out_valid     = valid_q;
    assign done          = done_q;
    assign busy          = (state_q != ST_IDLE);
    assign stage_index   = stage_out_q;
    assign old_address_0 = addr_q[0];
    assign old_address_1 = addr_q[1];
    assign old_address_2 = addr_q[2];
    assign old_address_3 = addr_q[3];
    assign old_address_4 = addr_q[4];
    assign old_address_5 = addr_q[5];
    assign old_address_6 = addr_q[6];
    assign old_address_7 = addr_q[7];
`ifdef NTT_TWIDDLE_INDEX_EN
    assign twiddle_index_0 = tw_q[0];
    assign twiddle_index_1 = tw_q[1];
    assign twiddle_index_2 = tw_q[2];
    assign twiddle_index_3 = tw_q[3];
`endif

endmodule
